// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART byte transmitter between
//               two byte sources, with burst limiting and an accept timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 4,
  parameter int ACCEPT_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  tx_busy,
  output logic                  sel,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  timeout_err
);

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);
  // The timeout pulse is registered, so it is decided one count early; the
  // counter reaches ACCEPT_TIMEOUT-1 on the same edge that raises the pulse.
  localparam logic [7:0] c_wait_last = 8'(ACCEPT_TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic                  r_sel, w_sel;
  logic                  r_ack0, w_ack0;
  logic                  r_ack1, w_ack1;
  logic                  r_tx_start, w_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data;
  logic                  r_timeout_err, w_timeout_err;
  logic                  r_last_grant, w_last_grant;
  logic [3:0]            r_burst_cnt, w_burst_cnt;
  logic [7:0]            r_wait_cnt, w_wait_cnt;
  logic                  w_grant;
  logic                  w_grant_idx;
  logic                  w_cur_req;
  logic                  w_oth_req;

  // State and output registers; reset puts requester 0 first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_sel         <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_timeout_err <= 1'b0;
      r_last_grant  <= 1'b1;
      r_burst_cnt   <= 4'd0;
      r_wait_cnt    <= 8'd0;
    end else begin
      r_state       <= w_state;
      r_sel         <= w_sel;
      r_ack0        <= w_ack0;
      r_ack1        <= w_ack1;
      r_tx_start    <= w_tx_start;
      r_tx_data     <= w_tx_data;
      r_timeout_err <= w_timeout_err;
      r_last_grant  <= w_last_grant;
      r_burst_cnt   <= w_burst_cnt;
      r_wait_cnt    <= w_wait_cnt;
    end
  end

  // Next-state logic: grant decisions, launch pulses and the accept timeout.
  always_comb begin
    w_state       = r_state;
    w_sel         = r_sel;
    w_ack0        = 1'b0;
    w_ack1        = 1'b0;
    w_tx_start    = 1'b0;
    w_tx_data     = r_tx_data;
    w_timeout_err = 1'b0;
    w_last_grant  = r_last_grant;
    w_burst_cnt   = r_burst_cnt;
    w_wait_cnt    = r_wait_cnt;
    w_grant       = 1'b0;
    w_grant_idx   = 1'b0;
    w_cur_req     = r_last_grant ? req1 : req0;
    w_oth_req     = r_last_grant ? req0 : req1;

    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_grant     = 1'b1;
          w_grant_idx = (req0 && req1) ? ~r_last_grant : req1;
          w_burst_cnt = 4'd1;
        end
      end
      LAUNCH: begin
        w_state    = WAIT_BUSY;
        w_wait_cnt = 8'd0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state = WAIT_DONE;
        end else begin
          w_wait_cnt = r_wait_cnt + 8'd1;
          if (r_wait_cnt == c_wait_last) begin
            w_timeout_err = 1'b1;
            w_burst_cnt   = 4'd0;
            w_state       = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (w_cur_req && (!w_oth_req || (r_burst_cnt < c_max_burst))) begin
            w_grant     = 1'b1;
            w_grant_idx = r_last_grant;
            w_burst_cnt = w_oth_req ? (r_burst_cnt + 4'd1) : 4'd1;
          end else if (w_oth_req) begin
            w_grant     = 1'b1;
            w_grant_idx = ~r_last_grant;
            w_burst_cnt = 4'd1;
          end else begin
            w_state = IDLE;
          end
        end
      end
      default: w_state = IDLE;
    endcase

    // Every grant, from IDLE or back-to-back, launches in the next cycle.
    if (w_grant) begin
      w_state      = LAUNCH;
      w_sel        = w_grant_idx;
      w_tx_data    = w_grant_idx ? data1 : data0;
      w_last_grant = w_grant_idx;
      w_tx_start   = 1'b1;
      w_ack0       = ~w_grant_idx;
      w_ack1       = w_grant_idx;
    end
  end

  assign sel         = r_sel;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_uart_tx_arbiter
// Description : Randomized self-checking bench for uart_tx_arbiter against a
//               transaction-level model of requesters and transmitter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int c_max_burst = 4;
  localparam int c_timeout   = 8;

  logic       clk;
  logic       reset;
  logic       req0, req1, tx_busy;
  logic [7:0] data0, data1;
  logic       sel, ack0, ack1, tx_start, timeout_err;
  logic [7:0] tx_data;

  uart_tx_arbiter #(
    .DATA_WIDTH    (8),
    .MAX_BURST     (c_max_burst),
    .ACCEPT_TIMEOUT(c_timeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .data0      (data0),
    .req1       (req1),
    .data1      (data1),
    .tx_busy    (tx_busy),
    .sel        (sel),
    .ack0       (ack0),
    .ack1       (ack1),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .timeout_err(timeout_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  // Pending bytes per requester and refill modes (0 off, 1 random, 2 always).
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int mode0, mode1, p_to;

  // Transaction model: last winner, burst length, the edge from which the
  // next grant may happen, whether that edge follows a completed frame, the
  // expected timeout edge and the edge window in which tx_busy is high.
  logic       m_last, m_sel, m_cont;
  logic [7:0] m_data;
  int m_burst, m_dec_edge, m_to_edge, m_lo, m_hi;

  logic       sr0, sr1;
  logic [7:0] sd0, sd1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic refill();
    if (q0.size() == 0 && (mode0 == 2 || (mode0 == 1 && $urandom_range(0, 7) == 0)))
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) q0.push_back(8'($urandom));
    if (q1.size() == 0 && (mode1 == 2 || (mode1 == 1 && $urandom_range(0, 7) == 0)))
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) q1.push_back(8'($urandom));
  endtask

  task automatic drive_inputs();
    req0    = (q0.size() > 0);
    data0   = req0 ? q0[0] : 8'h00;
    req1    = (q1.size() > 0);
    data1   = req1 ? q1[0] : 8'h00;
    tx_busy = ((k + 1) >= m_lo) && ((k + 1) <= m_hi);
  endtask

  task automatic model_check();
    int g;
    logic cur_req, oth_req, gsel;
    logic [4:0] exp_ctl;
    logic [7:0] exp_data;
    g = -1;
    if (k >= m_dec_edge) begin
      if (m_cont && k == m_dec_edge) begin
        cur_req = m_last ? sr1 : sr0;
        oth_req = m_last ? sr0 : sr1;
        if (cur_req && (!oth_req || m_burst < c_max_burst)) begin
          g       = int'(m_last);
          m_burst = oth_req ? m_burst + 1 : 1;
        end else if (oth_req) begin
          g       = int'(!m_last);
          m_burst = 1;
        end
      end else if (sr0 || sr1) begin
        g       = (sr0 && sr1) ? int'(!m_last) : int'(sr1);
        m_burst = 1;
      end
      if (g < 0) m_cont = 1'b0;
    end

    gsel     = (g >= 0) ? (g == 1) : m_sel;
    exp_ctl  = {g >= 0, g == 0, g == 1, gsel, k == m_to_edge};
    exp_data = (g == 0) ? sd0 : (g == 1) ? sd1 : m_data;
    check_eq("ctl{start,ack0,ack1,sel,tmo}",
             32'({tx_start, ack0, ack1, sel, timeout_err}), 32'(exp_ctl));
    check_eq("tx_data", 32'(tx_data), 32'(exp_data));

    if (g >= 0) begin
      m_sel  = (g == 1);
      m_last = (g == 1);
      m_data = exp_data;
      if (g == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
      if ($urandom_range(0, 99) < p_to) begin
        m_lo       = 0;
        m_hi       = -1;
        m_to_edge  = k + c_timeout;
        m_dec_edge = k + c_timeout + 1;
        m_cont     = 1'b0;
      end else begin
        int d, len;
        d          = int'($urandom_range(1, 5));
        len        = int'($urandom_range(1, 6));
        m_lo       = k + 1 + d;
        m_hi       = k + d + len;
        m_dec_edge = k + 1 + d + len;
        m_cont     = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    k++;
    sr0 = req0;
    sr1 = req1;
    sd0 = data0;
    sd1 = data1;
    @(negedge clk);
    model_check();
    refill();
    drive_inputs();
  endtask

  task automatic model_reset();
    m_last     = 1'b1;
    m_sel      = 1'b0;
    m_cont     = 1'b0;
    m_data     = 8'h00;
    m_burst    = 0;
    m_dec_edge = k + 1;
    m_to_edge  = -1;
    m_lo       = 0;
    m_hi       = -1;
  endtask

  task automatic do_mid_reset();
    int n;
    n = 0;
    while (!(k >= m_lo && k <= m_hi) && n < 300) begin
      cycle();
      n++;
    end
    check_eq("reach_wait_done", 32'(k >= m_lo && k <= m_hi), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_reset_outputs",
             32'({tx_start, ack0, ack1, sel, timeout_err, tx_data}), 32'd0);
    tx_busy = 1'b0;
    @(posedge clk);
    k++;
    @(negedge clk);
    check_eq("reset_hold_outputs",
             32'({tx_start, ack0, ack1, sel, timeout_err, tx_data}), 32'd0);
    reset = 1'b0;
    model_reset();
    refill();
    drive_inputs();
  endtask

  // Directed contention after reset, then randomized phases.
  initial begin
    reset = 1'b0;
    mode0 = 2;
    mode1 = 2;
    p_to  = 0;
    q0.push_back(8'h11);
    q1.push_back(8'h22);
    model_reset();
    m_lo = 0;
    m_hi = -1;
    drive_inputs();
    tx_busy = 1'b0;
    #1 reset = 1'b1;
    #1;
    check_eq("reset_outputs", 32'({tx_start, ack0, ack1, sel, timeout_err, tx_data}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs_clk", 32'({tx_start, ack0, ack1, sel, timeout_err, tx_data}), 32'd0);
    reset = 1'b0;
    model_reset();
    drive_inputs();

    repeat (300) cycle();           // both saturated: burst alternation
    mode0 = 0;
    repeat (200) cycle();           // requester 1 alone
    mode0 = 1;
    mode1 = 1;
    p_to  = 20;
    repeat (1500) cycle();          // sparse traffic with timeouts
    mode0 = 2;
    mode1 = 2;
    p_to  = 0;
    do_mid_reset();
    repeat (200) cycle();
    mode0 = 1;
    mode1 = 1;
    p_to  = 15;
    repeat (800) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter between two byte sources (requester 0, requester 1).
- Drives the select of the 2:1 transmit-data multiplexer and launches each byte into the transmitter with a start/busy handshake.
- Round-robin arbitration with a bounded burst length, so neither source can starve the other.
- Sits between the two message generators and the UART transmitter.

Parameters:
- DATA_WIDTH, 8, width of each byte source and of tx_data.
- MAX_BURST, 4, maximum consecutive bytes granted to one requester while the other is requesting; range 1..15.
- ACCEPT_TIMEOUT, 8, cycles allowed after tx_start for tx_busy to rise; range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 has a byte; held high with data0 stable until ack0.
- data0  input  DATA_WIDTH  requester 0 byte.
- req1  input  1  requester 1 has a byte; held high with data1 stable until ack1.
- data1  input  DATA_WIDTH  requester 1 byte.
- tx_busy  input  1  transmitter is sending a frame.
- sel  output  1  mux select: 0 = requester 0 path, 1 = requester 1 path.
- ack0  output  1  one-cycle pulse: data0 consumed.
- ack1  output  1  one-cycle pulse: data1 consumed.
- tx_start  output  1  one-cycle launch pulse to the transmitter.
- tx_data  output  DATA_WIDTH  byte presented to the transmitter, registered.
- timeout_err  output  1  one-cycle pulse: transmitter did not accept within ACCEPT_TIMEOUT.

Behaviour:
- All outputs are registered.
- Reset, asynchronous at any time, including mid-frame:
  - State goes to IDLE.
  - sel=0, ack0=ack1=0, tx_start=0, tx_data=0, timeout_err=0.
  - burst_cnt=0, wait_cnt=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Any frame already inside the transmitter is not tracked.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Only req0: grant 0. Only req1: grant 1. Both: grant ~last_grant.
  - On grant: sel <= granted index, tx_data <= granted data, last_grant <= granted index, burst_cnt <= 1, go to LAUNCH.
  - No request: stay in IDLE; sel and tx_data hold their values.
- LAUNCH lasts exactly one cycle:
  - tx_start=1 and ack of the granted requester=1 in this same cycle.
  - Go to WAIT_BUSY with wait_cnt=0.
  - Latency: req sampled high in IDLE at edge N gives tx_start/ack high in the cycle after edge N.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise wait_cnt increments each cycle.
  - wait_cnt reaches ACCEPT_TIMEOUT-1 with tx_busy still 0: pulse timeout_err for 1 cycle, go to IDLE, burst_cnt=0.
  - Nothing is re-sent on timeout; the byte was already acked.
- WAIT_DONE: wait for tx_busy=0. Then decide the next grant:
  - Current requester high and (other low, or burst_cnt < MAX_BURST): re-grant the same requester. burst_cnt increments, or is reset to 1 when the other requester is low.
  - Else if the other requester is high: grant the other requester, burst_cnt=1.
  - Else: go to IDLE.
  - On any re-grant, load tx_data from the newly granted requester and go directly to LAUNCH; no IDLE bubble.
- sel changes only on a grant decision. It is stable from LAUNCH through the end of WAIT_DONE.
- ack and tx_start never assert outside LAUNCH; at most one ack is high in any cycle.
- Requester 0 and requester 1 requests arriving in the same cycle count as contention.
- A req that drops before its ack (protocol violation) is ignored at the next decision point.
- tx_busy already high while in IDLE has no effect.

Test Plan:
- Single byte: req0=1, data0=8'hA5, tx_busy rises 2 cycles after tx_start and falls 10 cycles later -> sel=0, one tx_start with tx_data=8'hA5, one ack0 pulse, then IDLE; ack1 never asserts.
- Contention after reset: req0=req1=1 in the same cycle, each with one byte (8'h11 / 8'h22) -> tx_data sequence 8'h11 then 8'h22; sel 0 then 1; ack0 before ack1; no IDLE cycle between the frames.
- Burst limit, MAX_BURST=4: both requesters held high continuously -> grant pattern 0,0,0,0,1,1,1,1,0 in tx_start order; exactly one ack per tx_start.
- Solo burst: req1 held high, req0 low, 10 frames -> 10 consecutive grants to requester 1, sel=1 throughout, no forced switch.
- Timeout, ACCEPT_TIMEOUT=8: tx_busy held 0 after tx_start -> timeout_err pulses once, 8 cycles after tx_start; FSM returns to IDLE; the next req is granted normally.
- Reset mid-operation: assert reset during WAIT_DONE -> outputs go 0 in the same cycle without waiting for clk; after release with both requesters high, requester 0 is granted first.
